snake_ctrl_packet_tx: RTL and testbench

//  Transmit side of the snake control stream: debounces four raw direction buttons,

---
 rtl/snake_ctrl_packet_tx.sv | 171 +++++++++++++++++
 tb/tb_snake_ctrl_packet_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_ctrl_packet_tx.sv
// snake_ctrl_packet_tx
//   Transmit side of the snake control stream. Four raw direction buttons are
//   synchronised and debounced. A current heading is held. On every movement
//   tick, one single-beat 64-bit AXI-Stream control packet is emitted toward the
//   snake-head renderer.
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_enable               1 = game running, 0 = ticks suppressed
//   i_btn_up/down/left/right  raw asynchronous buttons, active-high
//   o_m_axis_tdata         [7:0] type 8'h00, [15:8] direction, [23:16] seq, [63:24] zero
//   o_m_axis_tvalid/tlast  packet valid; tlast mirrors tvalid
//   i_m_axis_tready        downstream ready
//   o_direction            held heading (0 none, 1 up, 2 down, 3 left, 4 right)
//   o_drop_count           ticks lost while a packet was pending, saturating
//
// FSM states
//   state   | meaning
//   ST_IDLE | no packet pending, waiting for a tick with a non-zero heading
//   ST_SEND | packet presented, held until tvalid && tready

module snake_ctrl_packet_tx #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 10_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_btn_up,
    input  logic        i_btn_down,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    output logic [63:0] o_m_axis_tdata,
    output logic        o_m_axis_tvalid,
    output logic        o_m_axis_tlast,
    input  logic        i_m_axis_tready,
    output logic [7:0]  o_direction,
    output logic [7:0]  o_drop_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LOAD = DW'(DEBOUNCE_CYCLES - 1);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    // bit order: 0 up, 1 down, 2 left, 3 right (also the priority order)
    logic [3:0]    w_btn_raw;
    logic [3:0]    r_sync1, r_sync2;
    logic [3:0]    r_db, r_db_d;
    logic [DW-1:0] r_db_cnt [4];

    logic [3:0]    w_press;
    logic [7:0]    w_req;
    logic [7:0]    w_opposite;
    logic          w_accept;
    logic [7:0]    r_dir;

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    state_t        r_state;
    logic [63:0]   r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic [7:0]    r_seq;
    logic [7:0]    r_drop;

    assign w_btn_raw = {i_btn_right, i_btn_left, i_btn_down, i_btn_up};

    // Debounce as a down-counter: reloaded on every agreeing cycle, the level
    // flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= DB_LOAD;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= DB_LOAD;
                end else if (r_db_cnt[i] == '0) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= DB_LOAD;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] - 1'b1;
                end
            end
        end
    end

    // The highest-priority press is chosen first. It is then rejected if it
    // would reverse the snake or repeat the current heading.
    always_comb begin
        w_press = r_db & ~r_db_d;
        w_req   = 8'd0;
        if (w_press[0])      w_req = 8'd1;
        else if (w_press[1]) w_req = 8'd2;
        else if (w_press[2]) w_req = 8'd3;
        else if (w_press[3]) w_req = 8'd4;
        case (r_dir)
            8'd1:    w_opposite = 8'd2;
            8'd2:    w_opposite = 8'd1;
            8'd3:    w_opposite = 8'd4;
            8'd4:    w_opposite = 8'd3;
            default: w_opposite = 8'd0;
        endcase
        w_accept = (w_req != 8'd0) && (w_req != w_opposite) && (w_req != r_dir);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_dir <= 8'd0;
        else if (w_accept) r_dir <= w_req;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                      r_tick_cnt <= '0;
        else if (!i_enable)             r_tick_cnt <= '0;
        else if (r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
        else                            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    assign w_tick = i_enable && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_seq    <= 8'd0;
            r_drop   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && (r_dir != 8'd0)) begin
                        r_tdata  <= {40'd0, r_seq, r_dir, 8'h00};
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b1;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (r_tvalid && i_m_axis_tready) begin
                        r_seq    <= r_seq + 8'd1;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                    // A tick on the handshake cycle is also lost: the packet
                    // just accepted already carried the current heading.
                    if (w_tick && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_m_axis_tdata  = r_tdata;
    assign o_m_axis_tvalid = r_tvalid;
    assign o_m_axis_tlast  = r_tlast;
    assign o_direction     = r_dir;
    assign o_drop_count    = r_drop;

endmodule

// File: tb/tb_snake_ctrl_packet_tx.sv
module tb_snake_ctrl_packet_tx;

    logic        clk;
    logic        i_rst;
    logic        i_enable;
    logic [3:0]  btns;   // 0 up, 1 down, 2 left, 3 right
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [7:0]  dir;
    logic [7:0]  drop;

    int total = 0;
    int bad   = 0;

    snake_ctrl_packet_tx #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_enable(i_enable),
        .i_btn_up(btns[0]),
        .i_btn_down(btns[1]),
        .i_btn_left(btns[2]),
        .i_btn_right(btns[3]),
        .o_m_axis_tdata(tdata),
        .o_m_axis_tvalid(tvalid),
        .o_m_axis_tlast(tlast),
        .i_m_axis_tready(tready),
        .o_direction(dir),
        .o_drop_count(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btns;
        int         hold;
        logic [7:0] exp_dir;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!tvalid && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", {63'd0, tvalid}, 64'd1);
    endtask

    initial begin
        int         n;
        logic       seen;
        logic       unstable;
        logic [63:0] held;

        // start from heading 4 (set by the debounce timing sequence)
        vecs[0]  = '{4'b0100, 10, 8'd4};  // left: opposite, ignored
        vecs[1]  = '{4'b1000, 10, 8'd4};  // right: same heading
        vecs[2]  = '{4'b0001, 3,  8'd4};  // up held 3 cycles: filtered
        vecs[3]  = '{4'b0001, 4,  8'd1};  // up held 4 cycles: accepted
        vecs[4]  = '{4'b0010, 10, 8'd1};  // down: opposite
        vecs[5]  = '{4'b1100, 10, 8'd3};  // left+right: left wins
        vecs[6]  = '{4'b1000, 10, 8'd3};  // right: opposite
        vecs[7]  = '{4'b1010, 10, 8'd2};  // down+right: down wins
        vecs[8]  = '{4'b0001, 10, 8'd2};  // up: opposite
        vecs[9]  = '{4'b1000, 10, 8'd4};  // right
        vecs[10] = '{4'b0011, 10, 8'd1};  // up+down: up wins
        vecs[11] = '{4'b1000, 10, 8'd4};  // right

        i_rst = 1'b0; i_enable = 1'b0; btns = 4'd0; tready = 1'b1;
        #2 i_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", {63'd0, tvalid}, 64'd0);
        check("rst_tlast", {63'd0, tlast}, 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_dir", {56'd0, dir}, 64'd0);
        check("rst_drop", {56'd0, drop}, 64'd0);
        i_rst = 1'b0;

        // no buttons: nothing sent
        i_enable = 1'b1;
        seen = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (tvalid) seen = 1'b1;
        end
        check("idle_no_valid", {63'd0, seen}, 64'd0);
        check("idle_dir", {56'd0, dir}, 64'd0);
        check("idle_drop", {56'd0, drop}, 64'd0);
        i_enable = 1'b0;
        @(negedge clk);

        // debounce latency: 2 sync + 4 stable + 1 heading register
        btns[3] = 1'b1;
        repeat (6) @(negedge clk);
        check("dir_before_accept", {56'd0, dir}, 64'd0);
        @(negedge clk);
        check("dir_after_accept", {56'd0, dir}, 64'd4);
        repeat (3) @(negedge clk);
        btns = 4'd0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            btns = vecs[i].btns;
            repeat (vecs[i].hold) @(negedge clk);
            btns = 4'd0;
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d_dir", i), {56'd0, dir}, {56'd0, vecs[i].exp_dir});
        end

        // glitchy up button: 3 high, 1 low, repeated
        repeat (3) begin
            btns[0] = 1'b1;
            repeat (3) @(negedge clk);
            btns[0] = 1'b0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_dir", {56'd0, dir}, 64'd4);

        // packets: first tick 16 cycles after enable, one cycle latency
        i_enable = 1'b1;
        wait_valid(40, n);
        check("first_latency", n, 16);
        check("pkt0_tdata", tdata, 64'h0000_0000_0000_0400);
        check("pkt0_tlast", {63'd0, tlast}, 64'd1);
        @(negedge clk);
        check("pkt0_done", {63'd0, tvalid}, 64'd0);
        wait_valid(40, n);
        check("pkt1_period", n, 15);
        check("pkt1_tdata", tdata, 64'h0000_0000_0001_0400);
        @(negedge clk);

        // backpressure: held for 40 cycles, two ticks dropped, heading change
        tready = 1'b0;
        wait_valid(40, n);
        check("pkt2_tdata", tdata, 64'h0000_0000_0002_0400);
        held = tdata;
        unstable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0)  btns[0] = 1'b1;
            if (i == 12) btns[0] = 1'b0;
            @(negedge clk);
            if (tvalid !== 1'b1 || tlast !== 1'b1 || tdata !== held) unstable = 1'b1;
        end
        check("stall_stable", {63'd0, unstable}, 64'd0);
        check("stall_dir", {56'd0, dir}, 64'd1);
        check("stall_drop", {56'd0, drop}, 64'd2);
        tready = 1'b1;
        @(negedge clk);
        check("stall_single_hs", {63'd0, tvalid}, 64'd0);
        check("stall_drop_after", {56'd0, drop}, 64'd2);
        wait_valid(40, n);
        check("pkt3_tdata", tdata, 64'h0000_0000_0003_0100);
        @(negedge clk);

        // async reset while a packet is pending
        tready = 1'b0;
        wait_valid(40, n);
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        check("midrst_tvalid", {63'd0, tvalid}, 64'd0);
        check("midrst_tlast", {63'd0, tlast}, 64'd0);
        check("midrst_tdata", tdata, 64'd0);
        check("midrst_dir", {56'd0, dir}, 64'd0);
        check("midrst_drop", {56'd0, drop}, 64'd0);
        @(negedge clk);
        i_rst = 1'b0; i_enable = 1'b0; tready = 1'b1;

        // simultaneous up+left from no heading
        btns = 4'b0101;
        repeat (10) @(negedge clk);
        btns = 4'd0;
        repeat (10) @(negedge clk);
        check("upleft_from0", {56'd0, dir}, 64'd1);

        // sequence number restarts at 0 after reset and wraps after 255
        i_enable = 1'b1;
        for (int p = 0; p < 257; p++) begin
            logic [7:0] s;
            s = p[7:0];
            wait_valid(40, n);
            check($sformatf("wrap_pkt%0d", p), tdata, {40'd0, s, 8'h01, 8'h00});
            @(negedge clk);
        end
        check("wrap_drop", {56'd0, drop}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
